// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with a stall-aware next-PC mux
// covering sequential, branch, jump and return sources.
// Optional return-address stack is built when the macro PC_RAS_EN is defined;
// without it, returns always use reg_target and the RAS status is constant.
module pc_sequencer #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump,
  input  logic            link,
  input  logic            ret,
  input  logic            branch_on_eq,
  input  logic            branch_on_neq,
  input  logic            zero,
  input  logic [15:0]     immediate16,
  input  logic [25:0]     immediate26,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_src,
  output logic [PC_W-1:0] target_address,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow
);

  logic [PC_W-1:0]        seq;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        jmp_tgt;
  logic [PC_W-1:0]        pc_nxt;
  logic [PC_W-1:0]        ras_top;
  logic signed [PC_W-1:0] br_off;
  logic                   br_taken;
  logic                   ras_hit;

  assign seq      = pc + PC_W'(1);
  assign br_off   = {{(PC_W-18){immediate16[15]}}, immediate16, 2'b00};
  assign br_tgt   = seq + $unsigned(br_off);
  assign br_taken = (branch_on_eq & zero) | (branch_on_neq & ~zero);

  // The jump keeps the PC region bits above bit 27, if the PC has any.
  if (PC_W > 28) begin : gen_jmp_region
    assign jmp_tgt = {pc[PC_W-1:28], immediate26, 2'b00};
  end else begin : gen_jmp_flat
    assign jmp_tgt = {immediate26, 2'b00};
  end

`ifdef PC_RAS_EN
  localparam int              PTR_W   = $clog2(RAS_DEPTH);
  localparam int              CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // top_ptr points at the next free slot; the top entry sits just below it.
  // When full, the next free slot is also the oldest entry, so a push
  // naturally overwrites it.
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr_en;
  logic             ovf_nxt;
  logic             call;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign call      = jump & link;
  assign top_idx   = top_ptr - PTR_W'(1);
  assign ras_hit   = (ras_cnt != '0);
  assign ras_top   = ras_mem[top_idx];
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_MAX);

  // Decide the RAS push / pop / replace for this cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = top_ptr;
    ptr_nxt = top_ptr;
    cnt_nxt = ras_cnt;
    ovf_nxt = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (ras_hit) begin
          if (call) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end else begin
            ptr_nxt = top_idx;
            cnt_nxt = ras_cnt - CNT_W'(1);
          end
        end else if (call) begin
          wr_en   = 1'b1;
          ptr_nxt = top_ptr + PTR_W'(1);
          cnt_nxt = cnt_sat_inc(ras_cnt);
        end
      end else if (call) begin
        wr_en   = 1'b1;
        ptr_nxt = top_ptr + PTR_W'(1);
        cnt_nxt = cnt_sat_inc(ras_cnt);
        ovf_nxt = (ras_cnt == CNT_MAX);
      end
    end
  end

  // RAS control state: pointer, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr      <= '0;
      ras_cnt      <= '0;
      ras_overflow <= 1'b0;
    end else begin
      top_ptr      <= ptr_nxt;
      ras_cnt      <= cnt_nxt;
      ras_overflow <= ovf_nxt;
    end
  end

  // RAS storage holds link addresses only; validity comes from the count.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= seq;
  end
`else
  logic unused_link;
  assign unused_link  = link;
  assign ras_hit      = 1'b0;
  assign ras_top      = '0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_overflow = 1'b0;
`endif

  // Redirect selection: ret, then jump, then taken branch.
  always_comb begin
    pc_src         = 1'b0;
    target_address = '0;
    if (ret) begin
      pc_src         = 1'b1;
      target_address = ras_hit ? ras_top : reg_target;
    end else if (jump) begin
      pc_src         = 1'b1;
      target_address = jmp_tgt;
    end else if (br_taken) begin
      pc_src         = 1'b1;
      target_address = br_tgt;
    end
  end

  assign pc_nxt = pc_src ? target_address : seq;

  // PC register, frozen while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_VECTOR;
    else if (!stall) pc <= pc_nxt;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the expected view of
// every cycle from a queue-based reference model, the monitor pops and
// compares on the falling edge. Works with or without PC_RAS_EN.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, jump, link, ret, branch_on_eq, branch_on_neq, zero;
  logic [15:0] immediate16;
  logic [25:0] immediate26;
  logic [31:0] reg_target;
  logic [31:0] pc, target_address;
  logic        pc_src, ras_empty, ras_full, ras_overflow;

  pc_sequencer #(.PC_W(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .link(link),
    .ret(ret), .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq),
    .zero(zero), .immediate16(immediate16), .immediate26(immediate26),
    .reg_target(reg_target), .pc(pc), .pc_src(pc_src),
    .target_address(target_address), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        src;
    logic [31:0] tgt;
    logic        emp;
    logic        full;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: a plain list of return addresses, newest last.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pc_src", 32'(pc_src), 32'(e.src));
        check("target_address", target_address, e.tgt);
        check("ras_empty", 32'(ras_empty), 32'(e.emp));
        check("ras_full", 32'(ras_full), 32'(e.full));
        check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic model_reset();
    m_pc  = 32'h100;
    m_ras.delete();
    m_ovf = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 0; jump = 0; link = 0; ret = 0; branch_on_eq = 0; branch_on_neq = 0;
    zero = 0; immediate16 = '0; immediate26 = '0; reg_target = '0;
  endtask

  // Assert reset `dly` after a rising edge; outputs must reset before the next edge.
  task automatic rst_cyc(input int dly);
    exp_t e;
    @(posedge clk);
    #(dly);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    e.pc = 32'h100; e.src = 0; e.tgt = '0; e.emp = 1; e.full = 0; e.ovf = 0;
    sb.push_back(e);
  endtask

  // One functional cycle: drive inputs, record expectation, advance the model.
  task automatic cyc(input logic st, input logic j, input logic l, input logic r,
                     input logic beq, input logic bne, input logic z,
                     input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rt);
    exp_t        e;
    logic [31:0] seq, tgt;
    logic        src;
    @(posedge clk);
    #1;
    reset = 0; stall = st; jump = j; link = l; ret = r; branch_on_eq = beq;
    branch_on_neq = bne; zero = z; immediate16 = i16; immediate26 = i26; reg_target = rt;
    seq = m_pc + 32'd1;
    src = 1'b1;
    if (r) begin
`ifdef PC_RAS_EN
      tgt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : rt;
`else
      tgt = rt;
`endif
    end else if (j) tgt = (m_pc & 32'hF000_0000) + 32'(i26) * 32'd4;
    else if ((beq && z) || (bne && !z)) tgt = seq + 32'($signed(i16)) * 32'd4;
    else begin
      src = 1'b0;
      tgt = '0;
    end
    e.pc = m_pc; e.src = src; e.tgt = tgt; e.ovf = m_ovf;
`ifdef PC_RAS_EN
    e.emp = (m_ras.size() == 0); e.full = (m_ras.size() == DEPTH);
`else
    e.emp = 1'b1; e.full = 1'b0;
`endif
    sb.push_back(e);
    m_ovf = 1'b0;
    if (!st) begin
      m_pc = src ? tgt : seq;
`ifdef PC_RAS_EN
      if (r) begin
        if (m_ras.size() > 0) begin
          if (j && l) m_ras[m_ras.size()-1] = seq;
          else void'(m_ras.pop_back());
        end else if (j && l) m_ras.push_back(seq);
      end else if (j && l) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(seq);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    // Reset, then sequential fetch.
    rst_cyc(1);
    rst_cyc(1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    // Branch from 0x10, taken and not taken.
    cyc(0, 1, 0, 0, 0, 0, 0, '0, 26'h4, '0);
    cyc(0, 0, 0, 0, 0, 1, 0, 16'hFFFF, '0, '0);
    cyc(0, 1, 0, 0, 0, 0, 0, '0, 26'h4, '0);
    cyc(0, 0, 0, 0, 0, 1, 1, 16'hFFFF, '0, '0);
    cyc(0, 0, 0, 0, 1, 0, 1, 16'h0010, '0, '0);
    // Call from 0x20 and return.
    cyc(0, 1, 0, 0, 0, 0, 0, '0, 26'h8, '0);
    cyc(0, 1, 1, 0, 0, 0, 0, '0, 26'h40, '0);
    cyc(0, 0, 0, 1, 0, 0, 0, '0, '0, 32'hDEAD);
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    // Five calls (overflow on the fifth), then five returns (last underflows).
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0, 0, 0, '0, 26'h100 + 26'(k * 16), '0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0, 0, 0, '0, '0, 32'hBEEF_0000 + 32'(k));
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    // ret together with call, on empty and on non-empty stack.
    cyc(0, 1, 1, 1, 0, 0, 0, '0, 26'h33, 32'h0000_0500);
    cyc(0, 1, 1, 1, 0, 0, 0, '0, 26'h33, 32'h0000_0600);
    cyc(0, 0, 1, 0, 0, 0, 0, '0, '0, '0);
    // Stall for three cycles with a jump pending, then release.
    repeat (3) cyc(1, 1, 1, 0, 0, 0, 0, '0, 26'h2A, '0);
    cyc(0, 1, 1, 0, 0, 0, 0, '0, 26'h2A, '0);
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    // Asynchronous reset mid-call and mid-stall.
    cyc(0, 1, 1, 0, 0, 0, 0, '0, 26'h77, '0);
    rst_cyc(3);
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    cyc(1, 1, 1, 0, 0, 0, 0, '0, 26'h12, '0);
    rst_cyc(3);
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) rst_cyc(3);
      else cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, 1'($urandom),
               $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), 26'($urandom), $urandom);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
